// File: rtl/cpu_display_driver.sv
// Eight-digit hex seven-segment driver for the CPU display/cycle outputs.
// Snapshots per frame, freezes at halt, debounced mode button.
module cpu_display_driver #(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] display,
   input  logic [31:0] cycle_count,
   input  logic        halt,
   input  logic        mode_btn,
   output logic [7:0]  seg,
   output logic [7:0]  an,
   output logic        mode,
   output logic        frozen
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [SW-1:0] scan_q, scan_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   disp_q, disp_d;
   logic [31:0]   cyc_q, cyc_d;
   logic          frozen_q, frozen_d;
   logic          mode_q, mode_d;
   logic          sync1_q, sync2_q;
   logic          lvl_q, lvl_d;
   logic          lvl_prev_q;
   logic [DW-1:0] db_q, db_d;
   logic [7:0]    an_q, an_d;
   logic [7:0]    seg_q, seg_d;

   logic          tick;
   logic          frame;
   logic [31:0]   val;
   logic [31:0]   shifted;
   logic [3:0]    nib;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   assign tick    = (scan_q == SW'(SCAN_DIV - 1));
   assign frame   = tick && (idx_q == 3'd7);
   assign val     = mode_q ? cyc_q : disp_q;
   assign shifted = val >> {idx_q, 2'b00};
   assign nib     = shifted[3:0];

   // Scan counter, snapshots with halt freeze, digit output values
   always_comb begin
      scan_d   = tick ? '0 : scan_q + SW'(1);
      idx_d    = tick ? idx_q + 3'd1 : idx_q;
      disp_d   = disp_q;
      cyc_d    = cyc_q;
      frozen_d = frozen_q;
      if (!frozen_q && (halt || frame)) begin
         disp_d = display;
         cyc_d  = cycle_count;
      end
      if (!frozen_q && halt)
         frozen_d = 1'b1;
      an_d  = ~(8'b1 << idx_q);
      seg_d = {~((idx_q == 3'd0) && frozen_q), hex7(nib)};
   end

   // Debounce counter and mode toggle on accepted press
   always_comb begin
      lvl_d  = lvl_q;
      db_d   = db_q + DW'(1);
      if (sync2_q == lvl_q) begin
         db_d = '0;
      end else if (db_q == DW'(DEBOUNCE_CYCLES - 1)) begin
         lvl_d = sync2_q;
         db_d  = '0;
      end
      mode_d = mode_q ^ (lvl_q & ~lvl_prev_q);
   end

   // State registers, all cleared asynchronously by clr
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         scan_q     <= '0;
         idx_q      <= '0;
         disp_q     <= '0;
         cyc_q      <= '0;
         frozen_q   <= 1'b0;
         mode_q     <= 1'b0;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         lvl_q      <= 1'b0;
         lvl_prev_q <= 1'b0;
         db_q       <= '0;
         an_q       <= 8'hFF;
         seg_q      <= 8'hFF;
      end else begin
         scan_q     <= scan_d;
         idx_q      <= idx_d;
         disp_q     <= disp_d;
         cyc_q      <= cyc_d;
         frozen_q   <= frozen_d;
         mode_q     <= mode_d;
         sync1_q    <= mode_btn;
         sync2_q    <= sync1_q;
         lvl_q      <= lvl_d;
         lvl_prev_q <= lvl_q;
         db_q       <= db_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign seg    = seg_q;
   assign an     = an_q;
   assign mode   = mode_q;
   assign frozen = frozen_q;

endmodule

// File: tb/tb_cpu_display_driver.sv
// Directed bench for cpu_display_driver (SCAN_DIV=4, DEBOUNCE_CYCLES=8).
// Expected digit patterns are hand-written constants.
module tb_cpu_display_driver;

   logic        clk;
   logic        clr;
   logic [31:0] display;
   logic [31:0] cycle_count;
   logic        halt;
   logic        mode_btn;
   logic [7:0]  seg;
   logic [7:0]  an;
   logic        mode;
   logic        frozen;

   int total = 0;
   int bad   = 0;
   int e     = 0;

   cpu_display_driver #(
      .SCAN_DIV(4),
      .DEBOUNCE_CYCLES(8)
   ) dut (
      .clk(clk),
      .clr(clr),
      .display(display),
      .cycle_count(cycle_count),
      .halt(halt),
      .mode_btn(mode_btn),
      .seg(seg),
      .an(an),
      .mode(mode),
      .frozen(frozen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      e++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic align();
      while (e % 32 != 0) step();
   endtask

   // Checks one full frame; exp holds {d7,...,d0} seg bytes
   task automatic check_frame(input string tag, input logic [63:0] exp);
      int d;
      logic [7:0] want_an;
      for (int k = 0; k < 32; k++) begin
         step();
         d = ((e - 1) / 4) % 8;
         want_an = ~(8'b1 << d);
         chk($sformatf("%s_an%0d", tag, k), {24'h0, an}, {24'h0, want_an});
         chk($sformatf("%s_seg%0d", tag, k), {24'h0, seg},
             {24'h0, exp[8*d +: 8]});
      end
   endtask

   task automatic press(input int hold);
      mode_btn = 1'b1;
      steps(hold);
      mode_btn = 1'b0;
      steps(15);
   endtask

   initial begin
      int n;
      logic m0;
      clr         = 1'b0;
      display     = 32'h1234ABCD;
      cycle_count = 32'h0;
      halt        = 1'b0;
      mode_btn    = 1'b0;
      #12;
      chk("rst_an", {24'h0, an}, 32'hFF);
      chk("rst_seg", {24'h0, seg}, 32'hFF);
      chk("rst_mode", {31'h0, mode}, 32'h0);
      chk("rst_frozen", {31'h0, frozen}, 32'h0);

      // 1: scan order, first frame zeros then 1234ABCD
      @(negedge clk);
      clr = 1'b1;
      e = 0;
      check_frame("f0", {8{8'hC0}});
      check_frame("f1", 64'hF9A4B099_8883C6A1);

      // 2: no tearing within a frame
      display = 32'h11111111;
      check_frame("tear_hold", 64'hF9A4B099_8883C6A1);
      for (int i = 0; i < 12; i++) begin
         step();
         chk("tear_pre", {24'h0, seg}, 32'hF9);
      end
      display = 32'h22222222;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("tear_mid", {24'h0, seg}, 32'hF9);
      end
      check_frame("tear_new", {8{8'hA4}});

      // 3: halt freeze, then mode to cycle count
      steps(3);
      halt        = 1'b1;
      display     = 32'h00000042;
      cycle_count = 32'd500;
      step();
      halt        = 1'b0;
      chk("halt_frozen", {31'h0, frozen}, 32'h1);
      display     = 32'hFFFFFFFF;
      cycle_count = 32'h0;
      align();
      check_frame("frz_disp", 64'hC0C0C0C0_C0C09924);
      press(15);
      chk("frz_mode", {31'h0, mode}, 32'h1);
      chk("frz_still", {31'h0, frozen}, 32'h1);
      align();
      check_frame("frz_cyc", 64'hC0C0C0C0_C0F98E19);

      // 4: debounce
      mode_btn = 1'b1;
      steps(5);
      mode_btn = 1'b0;
      steps(20);
      chk("glitch_mode", {31'h0, mode}, 32'h1);
      m0 = mode;
      mode_btn = 1'b1;
      n = 0;
      while (mode == m0 && n < 30) begin
         step();
         n++;
      end
      chk("db_lat", n, 11);
      steps(20 - n);
      chk("db_held", {31'h0, mode}, 32'h0);
      mode_btn = 1'b0;
      steps(15);
      chk("db_release", {31'h0, mode}, 32'h0);
      press(20);
      chk("db_again", {31'h0, mode}, 32'h1);

      // 5: async reset mid-frame while frozen with mode=1
      steps(6);
      #2;
      clr = 1'b0;
      #1;
      chk("arst_an", {24'h0, an}, 32'hFF);
      chk("arst_seg", {24'h0, seg}, 32'hFF);
      chk("arst_mode", {31'h0, mode}, 32'h0);
      chk("arst_frozen", {31'h0, frozen}, 32'h0);
      @(negedge clk);
      clr = 1'b1;
      e = 0;
      check_frame("post_f0", {8{8'hC0}});
      check_frame("post_f1", {8{8'h8E}});
      chk("post_frozen", {31'h0, frozen}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
